// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave
//   APB slave with a bank of NUM_REGS word registers addressed by word index.
//   Byte strobes, read-only registers (RO_MASK), PSLVERR for out-of-range
//   accesses and writes to read-only registers, programmable wait states and
//   a saturating error counter.
// Ports:
//   pclk, preset          bus clock, asynchronous active-low reset
//   psel, penable, pwrite APB control
//   paddr                 word index of the target register
//   pwdata, pstrb         write data and byte strobes
//   prdata                registered read data (holds until next read completes)
//   pready, pslverr       registered completion / error response
//   err_cnt               saturating count of error responses

// One register word with byte-enable writes.
module apb_regfile_word #(
    parameter int DATA_W = 32
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                we,
    input  logic [DATA_W/8-1:0] strb,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q
);
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            q <= '0;
        end else if (we) begin
            for (int k = 0; k < DATA_W/8; k++)
                if (strb[k]) q[8*k +: 8] <= wdata[8*k +: 8];
        end
    end
endmodule

module apb_regfile_slave #(
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  ADDR_W      = 32,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [7:0]          err_cnt
);
    localparam int STRB_W = DATA_W/8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } apb_req_t;

    state_t   state;
    apb_req_t req;
    logic [3:0] wcnt;

    logic [NUM_REGS-1:0][DATA_W-1:0] rf;
    logic [NUM_REGS-1:0]             reg_we;

    // The response is computed either at the setup edge (no wait states,
    // straight from the bus) or at the last wait edge (from the latched request).
    logic [ADDR_W-1:0] src_addr;
    logic              src_write;
    logic              src_oor;
    logic              src_err;
    logic [IDX_W-1:0]  src_idx;
    logic [DATA_W-1:0] src_rdata;

    always_comb begin
        src_addr  = (state == IDLE) ? paddr  : req.addr;
        src_write = (state == IDLE) ? pwrite : req.write;
        src_oor   = (src_addr >= ADDR_W'(NUM_REGS));
        src_idx   = src_addr[IDX_W-1:0];
        src_err   = src_oor || (src_write && RO_MASK[src_idx]);
        src_rdata = src_oor ? '0 : rf[src_idx];
    end

    // Commit happens only at the completion edge; the registered pslverr
    // already holds this transfer's error status and blocks the write.
    logic done;
    assign done = (state == ACCESS) && psel && penable && pready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign reg_we[gi] = done && req.write && !pslverr &&
                                (req.addr == ADDR_W'(gi));
            apb_regfile_word #(.DATA_W(DATA_W)) u_word (
                .pclk   (pclk),
                .preset (preset),
                .we     (reg_we[gi]),
                .strb   (req.strb),
                .wdata  (req.wdata),
                .q      (rf[gi])
            );
        end
    endgenerate

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state   <= IDLE;
            req     <= '0;
            wcnt    <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            err_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // penable without a prior setup phase is ignored
                    if (psel && !penable) begin
                        req.addr  <= paddr;
                        req.write <= pwrite;
                        req.wdata <= pwdata;
                        req.strb  <= pstrb;
                        wcnt      <= 4'(WAIT_STATES);
                        state     <= ACCESS;
                        if (WAIT_STATES == 0) begin
                            pready  <= 1'b1;
                            pslverr <= src_err;
                            if (!pwrite) prdata <= src_rdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        // abort: nothing committed, nothing counted
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end else if (pready) begin
                        if (penable) begin
                            state   <= IDLE;
                            pready  <= 1'b0;
                            pslverr <= 1'b0;
                            if (pslverr && err_cnt != 8'hFF)
                                err_cnt <= err_cnt + 8'd1;
                        end
                    end else if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                        if (wcnt == 4'd1) begin
                            pready  <= 1'b1;
                            pslverr <= src_err;
                            if (!req.write) prdata <= src_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave. Instance A: zero wait states, no
// read-only registers. Instance B: three wait states, register 0 read-only.
// Both share the bus except for their select lines.
module tb_apb_regfile_slave;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          pclk = 1'b0;
    logic          preset;
    logic          psel_a, psel_b, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [DW-1:0] prdata_a, prdata_b;
    logic          pready_a, pready_b, pslverr_a, pslverr_b;
    logic [7:0]    err_cnt_a, err_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_regfile_slave #(.DATA_W(DW), .NUM_REGS(8), .ADDR_W(AW),
                        .WAIT_STATES(0), .RO_MASK(8'h00)) dut_a (
        .pclk(pclk), .preset(preset), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
        .err_cnt(err_cnt_a));

    apb_regfile_slave #(.DATA_W(DW), .NUM_REGS(8), .ADDR_W(AW),
                        .WAIT_STATES(3), .RO_MASK(8'h01)) dut_b (
        .pclk(pclk), .preset(preset), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
        .err_cnt(err_cnt_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Call #1 after a rising edge; returns #1 after the completion edge,
    // so consecutive calls are back-to-back transfers.
    task automatic xfer(input bit b, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_rd, input bit exp_err,
                        input int exp_waits, input string tag);
        int         waits;
        bit         early;
        logic [31:0] rd;
        logic       err;
        paddr = a; pwrite = wr; pwdata = d; pstrb = s; penable = 1'b0;
        if (b) psel_b = 1'b1; else psel_a = 1'b1;
        @(posedge pclk); #1 penable = 1'b1;
        waits = 0;
        early = 1'b0;
        forever begin
            @(negedge pclk);
            if (b ? pready_b : pready_a) break;
            if (b ? pslverr_b : pslverr_a) early = 1'b1;
            waits++;
            if (waits > 20) break;
        end
        rd  = b ? prdata_b  : prdata_a;
        err = b ? pslverr_b : pslverr_a;
        @(posedge pclk); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
        chk({tag, ".waits"}, 64'(waits), 64'(exp_waits));
        chk({tag, ".pslverr"}, 64'(err), 64'(exp_err));
        chk({tag, ".err_wo_ready"}, 64'(early), 64'd0);
        if (!wr) chk({tag, ".prdata"}, 64'(rd), 64'(exp_rd));
    endtask

    initial begin
        bit seen;
        preset = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        #12;
        chk("rst.pready_a", 64'(pready_a), 64'd0);
        chk("rst.pslverr_a", 64'(pslverr_a), 64'd0);
        chk("rst.prdata_a", 64'(prdata_a), 64'd0);
        chk("rst.err_cnt_b", 64'(err_cnt_b), 64'd0);
        @(negedge pclk) preset = 1'b1;
        @(posedge pclk); #1;

        // zero-wait writes then reads
        xfer(0, 1, 0, 32'h00000309, 4'hF, 0, 0, 0, "w0");
        xfer(0, 1, 1, 32'h07122023, 4'hF, 0, 0, 0, "w1");
        xfer(0, 1, 2, 32'h444F4C5A, 4'hF, 0, 0, 0, "w2");
        xfer(0, 1, 3, 32'h44454E49, 4'hF, 0, 0, 0, "w3");
        xfer(0, 0, 0, 0, 4'h0, 32'h00000309, 0, 0, "r0");
        xfer(0, 0, 1, 0, 4'h0, 32'h07122023, 0, 0, "r1");
        xfer(0, 0, 2, 0, 4'h0, 32'h444F4C5A, 0, 0, "r2");
        xfer(0, 0, 3, 0, 4'h0, 32'h44454E49, 0, 0, "r3");

        // byte strobes, read issued back-to-back after the write
        xfer(0, 1, 1, 32'hAABBCCDD, 4'b0101, 0, 0, 0, "wstrb");
        xfer(0, 0, 1, 0, 4'h0, 32'h07BB20DD, 0, 0, "rstrb");

        // errors and wait states on instance B
        xfer(1, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 1, 3, "w_ro");
        xfer(1, 0, 0, 0, 4'h0, 32'h00000000, 0, 3, "r_ro");
        xfer(1, 1, 2, 32'h0000AAAA, 4'hF, 0, 0, 3, "w2b");
        xfer(1, 0, 2, 0, 4'h0, 32'h0000AAAA, 0, 3, "r2b");
        xfer(1, 0, 8, 0, 4'h0, 32'h00000000, 1, 3, "r_oor");
        chk("err_cnt_2", 64'(err_cnt_b), 64'd2);

        // abort: drop psel in the second ACCESS cycle
        paddr = 2; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
        penable = 1'b0; psel_b = 1'b1;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 psel_b = 1'b0; penable = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge pclk);
            if (pready_b) seen = 1'b1;
        end
        chk("abort.pready", 64'(seen), 64'd0);
        @(posedge pclk); #1;
        xfer(1, 0, 2, 0, 4'h0, 32'h0000AAAA, 0, 3, "abort.r2");
        chk("abort.err_cnt", 64'(err_cnt_b), 64'd2);

        // saturation
        for (int i = 0; i < 300; i++)
            xfer(1, 0, 32'(8 + (i % 4)), 0, 4'h0, 0, 1, 3, "sat");
        chk("err_cnt_sat", 64'(err_cnt_b), 64'd255);
        xfer(1, 0, 2, 0, 4'h0, 32'h0000AAAA, 0, 3, "sat.good");
        chk("err_cnt_hold", 64'(err_cnt_b), 64'd255);
        chk("err_cnt_a", 64'(err_cnt_a), 64'd0);

        // asynchronous reset in the ACCESS cycle of a write on A
        paddr = 0; pwrite = 1'b1; pwdata = 32'hDEADBEEF; pstrb = 4'hF;
        penable = 1'b0; psel_a = 1'b1;
        @(posedge pclk); #1 penable = 1'b1;
        #1;
        chk("pre_rst.pready_a", 64'(pready_a), 64'd1);
        #1 preset = 1'b0;
        #1;
        chk("arst.pready_a", 64'(pready_a), 64'd0);
        chk("arst.prdata_a", 64'(prdata_a), 64'd0);
        chk("arst.prdata_b", 64'(prdata_b), 64'd0);
        chk("arst.err_cnt_b", 64'(err_cnt_b), 64'd0);
        psel_a = 1'b0; penable = 1'b0;
        @(negedge pclk) preset = 1'b1;
        @(posedge pclk); #1;
        for (int i = 0; i < 4; i++)
            xfer(0, 0, 32'(i), 0, 4'h0, 32'h0, 0, 0, "post_rst.a");
        for (int i = 0; i < 8; i++)
            xfer(1, 0, 32'(i), 0, 4'h0, 32'h0, 0, 3, "post_rst.b");
        chk("post_rst.err_cnt_b", 64'(err_cnt_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
